// File: rtl/dpram_pkg.sv
// Shared sizing for the 16x8 dual-port RAM and the FIFO controller that sequences it.
// The pointer type carries one extra wrap bit above the RAM address.
package dpram_pkg;

    localparam int RAM_WIDTH = 8;
    localparam int RAM_DEPTH = 16;
    localparam int ADDR_SZ   = 4;

    typedef logic [ADDR_SZ:0] ptr_t;

    // Occupancy from wrap-bit pointers; modulo arithmetic makes wrap-around free.
    function automatic ptr_t ptr_count(input ptr_t wp, input ptr_t rp);
        return wp - rp;
    endfunction

endpackage

// File: rtl/dpram.sv
// 16x8 dual-port RAM: one synchronous write port, one registered read port.
// Contents are never reset; data_out only changes on an accepted read.
module dpram
    import dpram_pkg::*;
#(
    parameter int WIDTH = dpram_pkg::RAM_WIDTH,
    parameter int DEPTH = dpram_pkg::RAM_DEPTH,
    parameter int AW    = dpram_pkg::ADDR_SZ
) (
    input  logic             clk,
    input  logic             write,
    input  logic [AW-1:0]    wr_address,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    input  logic [AW-1:0]    rd_address,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (write) begin
            mem_q[wr_address] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (read) begin
            data_out_q <= mem_q[rd_address];
        end
    end

    assign data_out = data_out_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for the dual-port RAM: wrap-bit pointers, occupancy flags,
// registered almost-full, sticky overflow/underflow and a read-valid strobe.
module dpram_fifo_ctrl
    import dpram_pkg::*;
#(
    parameter int RAM_DEPTH = dpram_pkg::RAM_DEPTH,
    parameter int ADDR_SZ   = dpram_pkg::ADDR_SZ,
    parameter int AFULL_LVL = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic               clr_err,
    output logic               ram_write,
    output logic [ADDR_SZ-1:0] ram_wr_address,
    output logic               ram_read,
    output logic [ADDR_SZ-1:0] ram_rd_address,
    output logic               rd_valid,
    output logic               full,
    output logic               empty,
    output logic               afull,
    output logic [ADDR_SZ:0]   count,
    output logic               ovf,
    output logic               udf
);

    localparam logic [ADDR_SZ:0] AFULL_CNT = (ADDR_SZ+1)'(AFULL_LVL);
    localparam logic [ADDR_SZ:0] PTR_ONE   = (ADDR_SZ+1)'(1);

    logic [ADDR_SZ:0] wp_q, wp_d;
    logic [ADDR_SZ:0] rp_q, rp_d;
    logic [ADDR_SZ:0] count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             rd_valid_q, rd_valid_d;
    logic             afull_q, afull_d;
    logic             run_q;

    logic             empty_s;
    logic             full_s;
    logic             push_ok;
    logic             pop_ok;
    logic             push_err;
    logic             pop_err;

    assign empty_s = (wp_q == rp_q);
    assign full_s  = (wp_q[ADDR_SZ] != rp_q[ADDR_SZ]) &&
                     (wp_q[ADDR_SZ-1:0] == rp_q[ADDR_SZ-1:0]);

    // run_q holds requests off for the first edge after reset release.
    assign push_ok  = run_q & push & ~full_s  & ~flush;
    assign pop_ok   = run_q & pop  & ~empty_s & ~flush;
    assign push_err = run_q & push & full_s;
    assign pop_err  = run_q & pop  & empty_s;

    always_comb begin
        wp_d       = wp_q + (push_ok ? PTR_ONE : '0);
        rp_d       = rp_q + (pop_ok  ? PTR_ONE : '0);
        rd_valid_d = pop_ok;
        ovf_d      = ovf_q;
        udf_d      = udf_q;

        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (push_err) begin
            ovf_d = 1'b1;
        end
        if (pop_err) begin
            udf_d = 1'b1;
        end

        if (flush) begin
            wp_d       = '0;
            rp_d       = '0;
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
            rd_valid_d = 1'b0;
        end

        count_d = wp_d - rp_d;
        afull_d = (count_d >= AFULL_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            afull_q    <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
            rd_valid_q <= rd_valid_d;
            afull_q    <= afull_d;
            run_q      <= 1'b1;
        end
    end

    assign ram_write      = push_ok;
    assign ram_wr_address = wp_q[ADDR_SZ-1:0];
    assign ram_read       = pop_ok;
    assign ram_rd_address = rp_q[ADDR_SZ-1:0];

    assign rd_valid = rd_valid_q;
    assign full     = full_s;
    assign empty    = empty_s;
    assign afull    = afull_q;
    assign count    = wp_q - rp_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that sequences the 16×8 dual-port RAM as a first-in/first-out buffer. It accepts push/pop requests from a producer and a consumer and drives the RAM write port (`write`, `wr_address`) and read port (`read`, `rd_address`). It tracks occupancy, full/empty state, a programmable almost-full level and sticky error flags. RAM data passes straight through: `data_in` goes to the RAM directly, and `data_out` is qualified by `rd_valid`.

## Interface
- `RAM_DEPTH`, 16: number of RAM words; must be a power of two.
- `ADDR_SZ`, 4: log2(`RAM_DEPTH`); RAM address width.
- `AFULL_LVL`, 12: `afull` asserts when `count` ≥ this value.

Ports:
- `clk`  in  1  RAM/controller clock. Single clock; all logic on the rising edge.
- `rst_n`  in  1  Reset. Asynchronous, active-low.
- `push`  in  1  Producer write request, sampled on the rising edge of `clk`.
- `pop`  in  1  Consumer read request, sampled on the rising edge of `clk`.
- `flush`  in  1  Synchronous clear of pointers, count and error flags.
- `clr_err`  in  1  Synchronous clear of `ovf` and `udf`.
- `ram_write`  out  1  Drives the RAM `write` input.
- `ram_wr_address`  out  ADDR_SZ  Drives the RAM `wr_address` input.
- `ram_read`  out  1  Drives the RAM `read` input.
- `ram_rd_address`  out  ADDR_SZ  Drives the RAM `rd_address` input.
- `rd_valid`  out  1  The RAM `data_out` holds the popped word.
- `full`, `empty`, `afull`  out  1  Occupancy flags.
- `count`  out  ADDR_SZ+1  Number of words stored, 0..`RAM_DEPTH`.
- `ovf`, `udf`  out  1  Sticky overflow and underflow flags.

## Operation
- Pointers:
  - `wp` and `rp` are each ADDR_SZ+1 bits wide. The low ADDR_SZ bits are the RAM addresses.
  - Both wrap modulo 2·`RAM_DEPTH`.
- Flags:
  - `empty` = (`wp` == `rp`).
  - `full` = (MSBs differ) and (low bits equal).
  - `count` = `wp` − `rp`, computed modulo 2^(ADDR_SZ+1).
- Accept rules use the flags as registered at the current edge:
  - `push_ok` = `push` & !`full`.
  - `pop_ok` = `pop` & !`empty`.
- RAM drive signals are combinational:
  - `ram_write` = `push_ok`; `ram_wr_address` = `wp[ADDR_SZ-1:0]`.
  - `ram_read` = `pop_ok`; `ram_rd_address` = `rp[ADDR_SZ-1:0]`.
- Pointer update at the edge: `wp` += `push_ok`; `rp` += `pop_ok`.
- Push and pop in the same cycle:
  - Both are accepted when the FIFO is neither full nor empty, and `count` is unchanged.
  - When full, only the pop is accepted; the push is rejected and `ovf` is set.
  - When empty, only the push is accepted; the pop is rejected and `udf` is set.
- Read and write never target the same address in the same cycle. Equal addresses occur only when full or empty, and in both cases one side is blocked.
- Error flags:
  - `ovf` is set by `push` & `full`; `udf` is set by `pop` & `empty`.
  - Both hold until `clr_err`, `flush` or reset. If `clr_err` and a new error occur in the same cycle, the set wins.
- `flush`:
  - Sets `wp` = `rp` = 0 and clears `ovf`, `udf` and `rd_valid`.
  - Has priority over `push` and `pop` in the same cycle: no RAM write or read is issued.
- `afull` is registered: it equals (next `count` ≥ `AFULL_LVL`).

## Timing
- Reset values: `wp` = `rp` = 0, `empty` = 1, `full` = 0, `afull` = 0, `count` = 0, `ovf` = `udf` = 0, `rd_valid` = 0.
- `ram_write` and `ram_read` are 0 during reset.
- Write latency: a word pushed at edge N is poppable from edge N+1, since `empty` deasserts after edge N.
- Read latency:
  - A pop accepted at edge N puts the RAM `data_out` at edge N plus the RAM clock-to-output delay.
  - `rd_valid` is registered high from edge N until edge N+1, aligned with `data_out`.
- Back-to-back pops give one word per cycle, with `rd_valid` held high.
- Reset asserted mid-operation:
  - All state clears immediately and asynchronously; RAM contents are not cleared.
  - Reset deasserts synchronously to the design; the first push/pop is accepted on the second edge after release.

## Structure
- Shared package `dpram_pkg`: `RAM_WIDTH` = 8, `RAM_DEPTH` = 16, `ADDR_SZ` = 4, and the `ptr_t` (ADDR_SZ+1-bit) typedef.
- No sub-module inside the controller. The top level instantiates `dpram_fifo_ctrl` beside the RAM and wires `ram_*` to the RAM ports.

## Test plan
- Reset, then push 0x11, 0x22, 0x33, then pop ×3:
  - `data_out` = 0x11, 0x22, 0x33 on consecutive `rd_valid` cycles.
  - `count` reads 3 → 0 and `empty` = 1.
- Fill with 16 pushes:
  - `full` = 1, `count` = 16, `afull` set after the 12th push.
  - A 17th push sets `ovf` = 1, leaves `count` = 16 and does not pulse `ram_write`.
- Pop when empty:
  - `udf` = 1, `ram_read` = 0, `rd_valid` = 0.
  - `clr_err` then clears `udf`.
- Simultaneous push+pop:
  - At `count` = 5: `count` stays 5.
  - At full: `count` = 15 and `ovf` = 1.
  - At empty: `count` = 1 and `udf` = 1.
- Wrap: run 40 push/pop pairs with data = index. Every pop returns its index, and the pointer MSB toggles without false `full`/`empty`.
- Drop `rst_n` mid-burst at `count` = 7 and mid-clock: all outputs hit their reset values immediately, and a following push/pop sequence behaves normally.
